// File: rtl/rate_divider.sv
// -----------------------------------------------------------------------------
// rate_divider
//
// Produces the enable pulse that advances the downstream 4-bit T-flip-flop
// counter. A down-counter is loaded with PER(Sel)-1. While Run is high it
// counts down once per clock, and a one-cycle Tick is emitted each time it
// expires. While paused, a rising edge on Step produces a single Tick, so the
// counter can be advanced by hand.
//
// Ports:
//   Clk    in   system clock, rising-edge active
//   Clr    in   synchronous active-high reset (highest priority)
//   Run    in   1 = free-running ticks, 0 = paused (count frozen)
//   Step   in   manual step request, level; only its rising edge acts
//   Sel    in   [1:0] period select, picks P0..P3
//   Tick   out  registered one-cycle enable pulse for the counter's En
//   Count  out  [CNT_WIDTH-1:0] current down-counter value (debug/display)
// -----------------------------------------------------------------------------
module rate_divider #(
    parameter int          CNT_WIDTH = 28,
    parameter int unsigned P0        = 1,
    parameter int unsigned P1        = 50000000,
    parameter int unsigned P2        = 25000000,
    parameter int unsigned P3        = 12500000
) (
    input  logic                 Clk,
    input  logic                 Clr,
    input  logic                 Run,
    input  logic                 Step,
    input  logic [1:0]           Sel,
    output logic                 Tick,
    output logic [CNT_WIDTH-1:0] Count
);

    // Reload values are PER-1 truncated to the counter width, so a period of
    // exactly 2^CNT_WIDTH reloads to all ones.
    localparam logic [CNT_WIDTH-1:0] RELOAD0 = CNT_WIDTH'(P0 - 32'd1);
    localparam logic [CNT_WIDTH-1:0] RELOAD1 = CNT_WIDTH'(P1 - 32'd1);
    localparam logic [CNT_WIDTH-1:0] RELOAD2 = CNT_WIDTH'(P2 - 32'd1);
    localparam logic [CNT_WIDTH-1:0] RELOAD3 = CNT_WIDTH'(P3 - 32'd1);

    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 tick_q, tick_d;
    logic                 stepD_q;
    logic [1:0]           selD_q;

    logic [CNT_WIDTH-1:0] reloadVal;
    logic                 stepPulse;
    logic                 selChanged;

    // Reload value for the period currently selected.
    always_comb begin
        reloadVal = RELOAD0;
        case (Sel)
            2'd0:    reloadVal = RELOAD0;
            2'd1:    reloadVal = RELOAD1;
            2'd2:    reloadVal = RELOAD2;
            default: reloadVal = RELOAD3;
        endcase
    end

    assign stepPulse  = Step & ~stepD_q;
    assign selChanged = (Sel != selD_q);

    // A select change restarts the period and discards any expiry or step
    // in the same cycle. Otherwise, expiry applies when running and a step
    // applies when paused. A step that arrives while running is ignored.
    always_comb begin
        cnt_d  = cnt_q;
        tick_d = 1'b0;
        if (selChanged) begin
            cnt_d = reloadVal;
        end else if (Run) begin
            if (cnt_q == '0) begin
                tick_d = 1'b1;
                cnt_d  = reloadVal;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end else if (stepPulse) begin
            tick_d = 1'b1;
            cnt_d  = reloadVal;
        end
    end

    // State registers. The Step and Sel history is tracked on every edge so
    // that edge and change detection stay valid across pause and run.
    always_ff @(posedge Clk) begin
        if (Clr) begin
            cnt_q   <= reloadVal;
            tick_q  <= 1'b0;
            stepD_q <= 1'b0;
            selD_q  <= Sel;
        end else begin
            cnt_q   <= cnt_d;
            tick_q  <= tick_d;
            stepD_q <= Step;
            selD_q  <= Sel;
        end
    end

    assign Tick  = tick_q;
    assign Count = cnt_q;

endmodule

// File: tb/tb_rate_divider.sv
// -----------------------------------------------------------------------------
// tb_rate_divider
//
// Self-checking bench for rate_divider with CNT_WIDTH=4 and periods 1/4/3/6.
// Phase 1 applies a table of hand-derived vectors covering reset, the periods,
// pause/resume, stepping, select changes and reset in mid-period.
// Phase 2 drives random inputs and compares the outputs against a reference
// that counts elapsed running edges within the current period.
// -----------------------------------------------------------------------------
module tb_rate_divider;

    localparam int CW = 4;

    logic          Clk;
    logic          Clr;
    logic          Run;
    logic          Step;
    logic [1:0]    Sel;
    logic          Tick;
    logic [CW-1:0] Count;

    int nChecks;
    int nFails;

    rate_divider #(
        .CNT_WIDTH(CW),
        .P0(1),
        .P1(4),
        .P2(3),
        .P3(6)
    ) dut (
        .Clk  (Clk),
        .Clr  (Clr),
        .Run  (Run),
        .Step (Step),
        .Sel  (Sel),
        .Tick (Tick),
        .Count(Count)
    );

    // 10-unit clock period.
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct packed {
        logic          clr;
        logic          run;
        logic          step;
        logic [1:0]    sel;
        logic          expTick;
        logic [CW-1:0] expCount;
    } vec_t;

    vec_t vecs[$];

    // Reference-model state: running edges counted since the last restart.
    int  mElapsed;
    bit  mPrevStep;
    int  mPrevSel;
    bit  mTick;

    function automatic int periodOf(input int s);
        case (s)
            0:       return 1;
            1:       return 4;
            2:       return 3;
            default: return 6;
        endcase
    endfunction

    // Appends one table row.
    task automatic addVec(input logic c, input logic r, input logic s,
                          input logic [1:0] sl, input logic t, input int cnt);
        vec_t v;
        v.clr      = c;
        v.run      = r;
        v.step     = s;
        v.sel      = sl;
        v.expTick  = t;
        v.expCount = CW'(cnt);
        vecs.push_back(v);
    endtask

    // Drives inputs away from the active edge, then waits until just after
    // the next rising edge so that the outputs can be sampled.
    task automatic applyStimulus(input logic c, input logic r, input logic s,
                                 input logic [1:0] sl);
        @(negedge Clk);
        Clr  = c;
        Run  = r;
        Step = s;
        Sel  = sl;
        @(posedge Clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic expTick,
                               input logic [CW-1:0] expCount);
        nChecks++;
        if (Tick !== expTick) begin
            nFails++;
            $display("[TB] FAIL %s Tick: got %b expected %b", name, Tick, expTick);
        end
        nChecks++;
        if (Count !== expCount) begin
            nFails++;
            $display("[TB] FAIL %s Count: got %0d expected %0d", name, Count, expCount);
        end
    endtask

    // Advances the reference by one clock edge, using the inputs present at
    // that edge.
    task automatic modelEdge(input bit c, input bit r, input bit s, input int sl);
        bit rise;
        bit changed;
        if (c) begin
            mElapsed  = 0;
            mTick     = 0;
            mPrevStep = 0;
            mPrevSel  = sl;
        end else begin
            rise      = s && !mPrevStep;
            changed   = (sl != mPrevSel);
            mPrevStep = s;
            mPrevSel  = sl;
            if (changed) begin
                mElapsed = 0;
                mTick    = 0;
            end else if (r) begin
                mElapsed = mElapsed + 1;
                if (mElapsed >= periodOf(sl)) begin
                    mTick    = 1;
                    mElapsed = 0;
                end else begin
                    mTick = 0;
                end
            end else if (rise) begin
                mTick    = 1;
                mElapsed = 0;
            end else begin
                mTick = 0;
            end
        end
    endtask

    initial begin
        nChecks = 0;
        nFails  = 0;
        Clr  = 1'b1;
        Run  = 1'b0;
        Step = 1'b0;
        Sel  = 2'd1;

        // Reset, then a period of 4: ticks after running edges 4, 8 and 12.
        addVec(1,1,0,1, 0,3);
        addVec(1,1,0,1, 0,3);
        addVec(0,1,0,1, 0,2); addVec(0,1,0,1, 0,1); addVec(0,1,0,1, 0,0);
        addVec(0,1,0,1, 1,3); addVec(0,1,0,1, 0,2); addVec(0,1,0,1, 0,1);
        addVec(0,1,0,1, 0,0); addVec(0,1,0,1, 1,3); addVec(0,1,0,1, 0,2);
        addVec(0,1,0,1, 0,1); addVec(0,1,0,1, 0,0); addVec(0,1,0,1, 1,3);
        // Full rate: Tick is high on every running edge and low under Clr.
        addVec(1,1,0,0, 0,0);
        addVec(0,1,0,0, 1,0); addVec(0,1,0,0, 1,0); addVec(0,1,0,0, 1,0);
        addVec(1,1,0,0, 0,0);
        addVec(0,1,0,0, 1,0);
        // Pause and resume with a period of 6.
        addVec(1,1,0,3, 0,5);
        addVec(0,1,0,3, 0,4); addVec(0,1,0,3, 0,3);
        for (int i = 0; i < 5; i++) addVec(0,0,0,3, 0,3);
        addVec(0,1,0,3, 0,2); addVec(0,1,0,3, 0,1); addVec(0,1,0,3, 0,0);
        addVec(0,1,0,3, 1,5);
        // Stepping with a period of 3: one Tick per rising edge of Step.
        addVec(1,0,0,2, 0,2);
        addVec(0,0,1,2, 1,2);
        for (int i = 0; i < 4; i++) addVec(0,0,1,2, 0,2);
        addVec(0,0,0,2, 0,2);
        addVec(0,0,1,2, 1,2);
        addVec(0,0,0,2, 0,2);
        // A step while running adds nothing; the Tick here is an expiry.
        addVec(0,1,0,2, 0,1); addVec(0,1,1,2, 0,0); addVec(0,1,0,2, 1,2);
        addVec(0,1,1,2, 0,1);
        // Select change in mid-period restarts the period without a Tick.
        addVec(1,1,0,3, 0,5);
        addVec(0,1,0,3, 0,4); addVec(0,1,0,3, 0,3); addVec(0,1,0,3, 0,2);
        addVec(0,1,0,3, 0,1);
        addVec(0,1,0,2, 0,2); addVec(0,1,0,2, 0,1); addVec(0,1,0,2, 0,0);
        addVec(0,1,0,2, 1,2); addVec(0,1,0,2, 0,1); addVec(0,1,0,2, 0,0);
        // Select change at the expiry edge suppresses that Tick.
        addVec(0,1,0,1, 0,3);
        addVec(0,1,0,1, 0,2); addVec(0,1,0,1, 0,1); addVec(0,1,0,1, 0,0);
        addVec(0,1,0,1, 1,3);
        // Clr at Cnt==0 while running: no Tick, and the count reloads.
        addVec(0,1,0,1, 0,2); addVec(0,1,0,1, 0,1); addVec(0,1,0,1, 0,0);
        addVec(1,1,0,1, 0,3);
        addVec(0,1,0,1, 0,2);

        $display("[TB] Applying %0d table vectors", vecs.size());
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].clr, vecs[i].run, vecs[i].step, vecs[i].sel);
            checkOutput($sformatf("vec[%0d]", i), vecs[i].expTick, vecs[i].expCount);
        end

        // Random phase against the reference model, starting from a reset.
        $display("[TB] Random phase");
        begin
            bit c, r, s;
            int sl;
            sl = 1;
            s  = 0;
            applyStimulus(1'b1, 1'b1, 1'b0, 2'(sl));
            modelEdge(1, 1, 0, sl);
            checkOutput("rand_reset", mTick, CW'(periodOf(sl) - 1 - mElapsed));
            for (int n = 0; n < 600; n++) begin
                c = ($urandom_range(0, 39) == 0);
                r = ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 2) == 0) s = !s;
                if ($urandom_range(0, 15) == 0) sl = int'($urandom_range(0, 3));
                applyStimulus(c, r, s, 2'(sl));
                modelEdge(c, r, s, sl);
                checkOutput($sformatf("rand[%0d]", n), mTick,
                            CW'(periodOf(sl) - 1 - mElapsed));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
